// File: rtl/pixel_fetch_pkg.sv
// Shared widths, defaults and fetch-FSM state encoding for the pixel fetcher.
package pixel_fetch_pkg;
    localparam int ADDR_W = 24;
    localparam int WORD_W = 16;
    localparam int IDX_W  = 4;
    localparam logic [IDX_W-1:0] UNDERFLOW_INDEX_DEF = 4'h8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } fetch_state_t;
endpackage

// File: rtl/pixel_fetch_if.sv
// SDRAM read-port bundle between the pixel fetcher (master) and the controller (slave).
interface pixel_fetch_if;
    import pixel_fetch_pkg::*;

    logic [ADDR_W-1:0] rd_addr;
    logic              rd_enable;
    logic              busy;
    logic              rd_ready;
    logic [WORD_W-1:0] rd_data;

    modport master (
        output rd_addr, rd_enable,
        input  busy, rd_ready, rd_data
    );

    modport slave (
        input  rd_addr, rd_enable,
        output busy, rd_ready, rd_data
    );
endinterface

// File: rtl/pixel_fetch_word_fifo.sv
// Synchronous word FIFO; flush beats push, and push into a full FIFO is allowed when a pop frees a slot.
module pixel_fetch_word_fifo
    import pixel_fetch_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WORD_W-1:0]          wdata,
    input  logic                       pop,
    output logic [WORD_W-1:0]          head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = DEPTH[CNT_W-1:0];

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/pixel_fetch.sv
// Fetches packed 4-bit palette indices from SDRAM and emits one per DrawArea cycle.
// Optional PIXEL_FETCH_STATS_EN adds a saturating underflow_count output.
module pixel_fetch
    import pixel_fetch_pkg::*;
#(
    parameter int                H_ACTIVE        = 640,
    parameter int                V_ACTIVE        = 480,
    parameter logic [ADDR_W-1:0] BASE_ADDR       = 24'h000000,
    parameter int                FIFO_DEPTH      = 16,
    parameter logic [IDX_W-1:0]  UNDERFLOW_INDEX = UNDERFLOW_INDEX_DEF
) (
    input  logic              pixclk,
    input  logic              rst,
    input  logic              animate,
    input  logic              DrawArea,
    pixel_fetch_if.master     sd,
    output logic [IDX_W-1:0]  pix_index,
`ifdef PIXEL_FETCH_STATS_EN
    output logic [15:0]       underflow_count,
`endif
    output logic              underflow
);
    // state | meaning
    // IDLE  | no read outstanding; waits for FIFO room and frame budget
    // REQ   | rd_enable held until the controller drops busy
    // WAIT  | request accepted; waiting for rd_ready
    localparam int FRAME_WORDS = H_ACTIVE * V_ACTIVE / 4;
    localparam int WI_W        = $clog2(FRAME_WORDS + 1);
    localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);
    localparam logic [WI_W-1:0] FRAME_LIM = FRAME_WORDS[WI_W-1:0];
    localparam logic [CNT_W:0]  DEPTH_LIM = FIFO_DEPTH[CNT_W:0];

    fetch_state_t      state;
    fetch_state_t      state_nx;
    logic [WI_W-1:0]   words_issued;
    logic              discard;
    logic [1:0]        nibble;
    logic [WORD_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              accept;
    logic              resp;

    always_ff @(posedge pixclk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        sd.rd_enable = 1'b0;
        accept       = 1'b0;
        resp         = 1'b0;
        case (state)
            IDLE: begin
                if (!animate && ({1'b0, fifo_count} + 1'b1 <= DEPTH_LIM) &&
                    (words_issued < FRAME_LIM))
                    state_nx = REQ;
            end
            REQ: begin
                sd.rd_enable = 1'b1;
                if (animate) begin
                    state_nx = IDLE;
                end else if (!sd.busy) begin
                    accept   = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (sd.rd_ready) begin
                    resp     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign fifo_push = resp && !discard && !animate;
    assign fifo_pop  = DrawArea && !fifo_empty && (nibble == 2'd3);

    always_ff @(posedge pixclk) begin
        if (rst) begin
            sd.rd_addr   <= BASE_ADDR;
            words_issued <= '0;
            discard      <= 1'b0;
        end else if (animate) begin
            sd.rd_addr   <= BASE_ADDR;
            words_issued <= '0;
            // A response still in flight belongs to the old frame and must be dropped.
            discard      <= (state == WAIT) && !sd.rd_ready;
        end else begin
            if (accept)    words_issued <= words_issued + 1'b1;
            if (fifo_push) sd.rd_addr   <= sd.rd_addr + 1'b1;
            if (resp)      discard      <= 1'b0;
        end
    end

    always_ff @(posedge pixclk) begin
        if (rst) begin
            pix_index <= '0;
            nibble    <= '0;
            underflow <= 1'b0;
        end else begin
            if (!DrawArea)       pix_index <= '0;
            else if (!fifo_empty) pix_index <= fifo_head[{nibble, 2'b00} +: IDX_W];
            else                 pix_index <= UNDERFLOW_INDEX;

            if (animate) begin
                nibble    <= '0;
                underflow <= 1'b0;
            end else begin
                if (DrawArea && !fifo_empty) nibble    <= nibble + 1'b1;
                if (DrawArea && fifo_empty)  underflow <= 1'b1;
            end
        end
    end

`ifdef PIXEL_FETCH_STATS_EN
    always_ff @(posedge pixclk) begin
        if (rst || animate)
            underflow_count <= '0;
        else if (DrawArea && fifo_empty && (underflow_count != 16'hFFFF))
            underflow_count <= underflow_count + 1'b1;
    end
`endif

    pixel_fetch_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_word_fifo (
        .clk   (pixclk),
        .rst   (rst),
        .flush (animate),
        .push  (fifo_push),
        .wdata (sd.rd_data),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty)
    );
endmodule

// File: tb/tb_pixel_fetch.sv
// Self-checking bench for pixel_fetch: SDRAM responder + pixel scoreboard, vector table and corner sequences.
module tb_pixel_fetch;
    import pixel_fetch_pkg::*;

    localparam int H     = 32;
    localparam int V     = 8;
    localparam int DEPTH = 16;
    localparam int FW    = H * V / 4;

    logic             pixclk = 1'b0;
    logic             rst;
    logic             animate;
    logic             DrawArea;
    logic [IDX_W-1:0] pix_index;
    logic             underflow;
`ifdef PIXEL_FETCH_STATS_EN
    logic [15:0]      underflow_count;
`endif

    pixel_fetch_if sd();

    pixel_fetch #(
        .H_ACTIVE        (H),
        .V_ACTIVE        (V),
        .BASE_ADDR       (24'h000000),
        .FIFO_DEPTH      (DEPTH),
        .UNDERFLOW_INDEX (4'h8)
    ) dut (
        .pixclk          (pixclk),
        .rst             (rst),
        .animate         (animate),
        .DrawArea        (DrawArea),
        .sd              (sd),
        .pix_index       (pix_index),
`ifdef PIXEL_FETCH_STATS_EN
        .underflow_count (underflow_count),
`endif
        .underflow       (underflow)
    );

    always #5 pixclk = ~pixclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [23:0] a);
        if (a == 24'd0) return 16'h3210;
        if (a == 24'd1) return 16'h7654;
        return {a[3:0], ~a[3:0], a[7:4], a[3:0] ^ 4'h5};
    endfunction

    // Responder and scoreboard state; main process only writes the control knobs.
    logic        busy_req  = 1'b0;
    logic        stall     = 1'b0;
    logic        ffff_next = 1'b0;
    int          lat_cfg   = 0;
    logic [3:0]  nib_q[$];
    logic        pend;
    logic        pend_drop;
    logic [23:0] pend_addr;
    int          lat_cnt;
    logic [23:0] exp_addr;
    logic [3:0]  exp_pix;
    logic        exp_uf;
    int          exp_ucnt;
    int          req_cnt = 0;
    logic [23:0] last_acc_addr = '0;

    initial begin
        logic [15:0] d;
        sd.busy = 1'b0; sd.rd_ready = 1'b0; sd.rd_data = '0;
        pend = 1'b0; pend_drop = 1'b0; pend_addr = '0; lat_cnt = 0;
        exp_addr = '0; exp_pix = '0; exp_uf = 1'b0; exp_ucnt = 0;
        forever begin
            @(negedge pixclk);
            #1;
            check("pix_sb", 32'(pix_index), 32'(exp_pix));
            check("uf_sb", 32'(underflow), 32'(exp_uf));
`ifdef PIXEL_FETCH_STATS_EN
            check("ucnt_sb", 32'(underflow_count), 32'(exp_ucnt));
`endif
            sd.rd_ready = 1'b0;
            sd.busy     = busy_req;
            if (rst) begin
                nib_q.delete();
                pend = 1'b0; pend_drop = 1'b0;
                exp_addr = '0; exp_pix = '0; exp_uf = 1'b0; exp_ucnt = 0;
            end else begin
                if (DrawArea) begin
                    if (nib_q.size() > 0) exp_pix = nib_q.pop_front();
                    else begin
                        exp_pix = 4'h8;
                        exp_uf  = 1'b1;
                        if (exp_ucnt < 65535) exp_ucnt++;
                    end
                end else exp_pix = '0;
                if (animate) begin
                    nib_q.delete();
                    exp_addr = '0; exp_uf = 1'b0; exp_ucnt = 0;
                    if (pend) pend_drop = 1'b1;
                end
                if (pend && !stall) begin
                    if (lat_cnt == 0) begin
                        d = ffff_next ? 16'hFFFF : mem_word(pend_addr);
                        sd.rd_ready = 1'b1;
                        sd.rd_data  = d;
                        if (!pend_drop) begin
                            for (int k = 0; k < 4; k++) nib_q.push_back(d[4*k +: 4]);
                            exp_addr = exp_addr + 24'd1;
                        end
                        pend = 1'b0; pend_drop = 1'b0;
                    end else lat_cnt--;
                end
                if (sd.rd_enable && !sd.busy && !animate) begin
                    check("req_addr", 32'(sd.rd_addr), 32'(exp_addr));
                    req_cnt++;
                    last_acc_addr = sd.rd_addr;
                    pend = 1'b1; pend_drop = 1'b0;
                    pend_addr = sd.rd_addr;
                    lat_cnt = lat_cfg;
                end
            end
        end
    end

    typedef struct {
        logic       draw;
        logic [3:0] pix;
        logic       uf;
    } vec_t;
    vec_t vec[10];

    initial begin
        int rb;
        int t;
        logic [23:0] addr_hold;
        rst = 1'b1; animate = 1'b0; DrawArea = 1'b0;
        for (int i = 0; i < 8; i++) vec[i] = '{1'b1, 4'(i), 1'b0};
        vec[8] = '{1'b0, 4'h0, 1'b0};
        vec[9] = '{1'b0, 4'h0, 1'b0};

        repeat (3) @(negedge pixclk);
        check("rst_addr", 32'(sd.rd_addr), 32'h0);
        check("rst_en", 32'(sd.rd_enable), 32'h0);
        check("rst_pix", 32'(pix_index), 32'h0);
        check("rst_uf", 32'(underflow), 32'h0);
        rst = 1'b0;

        // Frame start, FIFO fill, then the first eight pixels from words 0 and 1.
        animate = 1'b1; @(negedge pixclk); animate = 1'b0;
        repeat (60) @(negedge pixclk);
        for (int i = 0; i < 10; i++) begin
            DrawArea = vec[i].draw;
            @(negedge pixclk);
            check("vec_pix", 32'(pix_index), 32'(vec[i].pix));
            check("vec_uf", 32'(underflow), 32'(vec[i].uf));
        end

        // Busy held during REQ: request and address stay put, one acceptance afterwards.
        repeat (10) @(negedge pixclk);
        busy_req = 1'b1;
        DrawArea = 1'b1; repeat (4) @(negedge pixclk); DrawArea = 1'b0;
        repeat (3) @(negedge pixclk);
        rb = req_cnt; addr_hold = exp_addr;
        for (int i = 0; i < 10; i++) begin
            @(negedge pixclk);
            check("busy_en", 32'(sd.rd_enable), 32'h1);
            check("busy_addr", 32'(sd.rd_addr), 32'(addr_hold));
        end
        busy_req = 1'b0;
        repeat (6) @(negedge pixclk);
        check("busy_one_req", 32'(req_cnt - rb), 32'h1);
        check("busy_addr_inc", 32'(sd.rd_addr), 32'(addr_hold + 24'd1));
        check("busy_en_low", 32'(sd.rd_enable), 32'h0);

        // Starve the FIFO: 64 buffered pixels then 16 underflow pixels.
        stall = 1'b1;
        DrawArea = 1'b1; repeat (80) @(negedge pixclk);
        check("uf_pix", 32'(pix_index), 32'h8);
        check("uf_flag", 32'(underflow), 32'h1);
`ifdef PIXEL_FETCH_STATS_EN
        check("uf_count", 32'(underflow_count), 32'd16);
`endif
        DrawArea = 1'b0; @(negedge pixclk);

        // Animate while a read is outstanding; the late 16'hFFFF response must be dropped.
        ffff_next = 1'b1;
        animate = 1'b1; @(negedge pixclk); animate = 1'b0;
        check("anim_uf_clr", 32'(underflow), 32'h0);
`ifdef PIXEL_FETCH_STATS_EN
        check("anim_ucnt_clr", 32'(underflow_count), 32'h0);
`endif
        rb = req_cnt;
        repeat (3) @(negedge pixclk);
        stall = 1'b0;
        @(negedge pixclk);
        ffff_next = 1'b0;
        t = 0;
        while (req_cnt == rb && t < 20) begin
            @(negedge pixclk);
            t++;
        end
        check("anim_new_req", 32'(req_cnt - rb), 32'h1);
        check("anim_base_addr", 32'(last_acc_addr), 32'h0);
        repeat (10) @(negedge pixclk);
        DrawArea = 1'b1; @(negedge pixclk); DrawArea = 1'b0;
        check("anim_first_pix", 32'(pix_index), 32'h0);

        // Mid-frame reset, then no DrawArea: exactly DEPTH words fetched.
        rst = 1'b1; repeat (2) @(negedge pixclk); rst = 1'b0;
        rb = req_cnt;
        repeat (100) @(negedge pixclk);
        check("nodraw_reqs", 32'(req_cnt - rb), 32'(DEPTH));
        check("nodraw_en", 32'(sd.rd_enable), 32'h0);

        // Whole small frame with blanking gaps.
        animate = 1'b1; @(negedge pixclk); animate = 1'b0;
        rb = req_cnt;
        repeat (60) @(negedge pixclk);
        for (int ln = 0; ln < V; ln++) begin
            DrawArea = 1'b1; repeat (H) @(negedge pixclk);
            DrawArea = 1'b0; repeat (8) @(negedge pixclk);
        end
        repeat (20) @(negedge pixclk);
        check("frame_reqs", 32'(req_cnt - rb), 32'(FW));
        check("frame_uf", 32'(underflow), 32'h0);
        check("frame_en_done", 32'(sd.rd_enable), 32'h0);
        check("frame_addr_end", 32'(sd.rd_addr), 32'(FW));
`ifdef PIXEL_FETCH_STATS_EN
        check("frame_ucnt", 32'(underflow_count), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
